multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main control state machine for the multicycle RV32I core.
- Sits directly upstream of the register file and drives its regWrite strobe. Also drives the PC, IR, memory and ALU-operand mux controls that select which data reach the register file's writeData port.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, with a wait handshake on memory.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes occur on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  7  instruction bits [6:0], taken from the instruction register.
- memReady  input  1  memory handshake: the access requested this cycle completes this cycle.
- pcWrite  output  1  unconditional PC load.
- pcWriteCond  output  1  PC load qualified by the datapath branch-taken flag.
- pcSource  output  1  0 = ALU result, 1 = ALUOut register.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memRead  output  1  memory read request.
- memWrite  output  1  memory write request.
- irWrite  output  1  load IR; also latches oldPC.
- regWrite  output  1  register file write enable.
- memToReg  output  2  writeData select: 00 ALUOut, 01 MDR, 10 PC, 11 immediate.
- aluSrcA  output  2  ALU A select: 00 PC, 01 oldPC, 10 register A.
- aluSrcB  output  2  ALU B select: 00 register B, 01 constant 4, 10 immediate.
- aluOp  output  2  00 add, 01 branch compare, 10 R-type funct decode, 11 I-type funct decode.
- illegalOp  output  1  one-cycle pulse in DECODE when the opcode is unsupported.
- state  output  4  current state encoding, for debug.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- State register encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JAL=10, LUI=11.
- Any other state value goes to FETCH on the next edge, and all strobes are 0 while in it.
- Outputs are Moore: decoded combinationally from state, plus memReady where noted below.
- Any output not listed for a state is 0.
- Reset: state=FETCH and instret=0, applied immediately and asynchronously. While rst=1, pcWrite, pcWriteCond, irWrite, regWrite, memRead and memWrite are all forced to 0.
- FETCH:
  - Asserts memRead; IorD=0, aluSrcA=00, aluSrcB=01, aluOp=00, pcSource=0.
  - irWrite=pcWrite=memReady.
  - Stays in FETCH while memReady=0; goes to DECODE when memReady=1.
- DECODE:
  - aluSrcA=01, aluSrcB=10, aluOp=00; this precomputes the branch/JAL target into ALUOut.
  - Next state by opcode:
    - 0000011 or 0100011 -> MEM_ADDR.
    - 0110011 -> EXEC_R.
    - 0010011 -> EXEC_I.
    - 1100011 -> BRANCH.
    - 1101111 -> JAL.
    - 0110111 -> LUI.
    - Any other opcode -> FETCH, with illegalOp=1 for this cycle and no instret increment.
- MEM_ADDR: aluSrcA=10, aluSrcB=10, aluOp=00. Next state is MEM_READ if opcode=0000011, otherwise MEM_WRITE.
- MEM_READ: memRead=1, IorD=1. Holds while memReady=0; goes to MEM_WB when memReady=1.
- MEM_WB: regWrite=1, memToReg=01 -> FETCH.
- MEM_WRITE: memWrite=1, IorD=1. Holds while memReady=0; goes to FETCH when memReady=1. memWrite stays high for every held cycle.
- EXEC_R: aluSrcA=10, aluSrcB=00, aluOp=10 -> ALU_WB.
- EXEC_I: aluSrcA=10, aluSrcB=10, aluOp=11 -> ALU_WB.
- ALU_WB: regWrite=1, memToReg=00 -> FETCH.
- BRANCH: aluSrcA=10, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=1 -> FETCH.
- JAL: regWrite=1, memToReg=10, pcWrite=1, pcSource=1 -> FETCH.
  - The PC still holds PC+4 from FETCH, so rd receives the return address.
  - rd=x0 is suppressed by the register file.
- LUI: regWrite=1, memToReg=11 -> FETCH.
- instret:
  - Increments by 1 on each edge that leaves MEM_WB, MEM_WRITE (with memReady=1), ALU_WB, BRANCH, JAL or LUI for FETCH.
  - Wraps modulo 2^CNT_W with no flag.
- Reset asserted mid-instruction: the instruction is abandoned, with no completing write strobe after rst rises. After rst falls, the first edge evaluates FETCH.
- Latency with memReady tied to 1:
  - R/I/JAL/LUI: 3 or 4 cycles (R/I=4, JAL/LUI=3).
  - Branch: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.

Test Plan:
- Reset with memReady=1 and opcode=0110011 -> state sequence 0,1,6,8,0. regWrite=1 only in state 8; instret=1 after 4 cycles.
- Load with opcode=0000011, memReady held 0 for 3 cycles in MEM_READ -> MEM_READ lasts 4 cycles; MEM_WB asserts regWrite=1 with memToReg=01; total 8 cycles.
- Store with opcode=0100011 -> states 0,1,2,5,0. memWrite=1 and IorD=1 only in state 5; regWrite is never 1.
- Opcode=1111111 -> illegalOp pulses for 1 cycle in DECODE, then FETCH; instret is unchanged; no write strobes are asserted.
- Reset during MEM_WRITE while memReady=0 -> memWrite drops to 0 asynchronously, state=0, instret=0.
- CNT_W=4: retire 16 LUI instructions -> instret wraps from 15 to 0.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the RV32I datapath.
//   master : the control FSM. It takes opcode/memReady and drives every control strobe,
//            the debug state and the retired-instruction count.
//   slave  : the datapath/memory side, which sees the same signals in the other direction.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             memReady;
  logic             pcWrite;
  logic             pcWriteCond;
  logic             pcSource;
  logic             IorD;
  logic             memRead;
  logic             memWrite;
  logic             irWrite;
  logic             regWrite;
  logic [1:0]       memToReg;
  logic [1:0]       aluSrcA;
  logic [1:0]       aluSrcB;
  logic [1:0]       aluOp;
  logic             illegalOp;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, memReady,
    output pcWrite, pcWriteCond, pcSource, IorD, memRead, memWrite, irWrite,
           regWrite, memToReg, aluSrcA, aluSrcB, aluOp, illegalOp, state, instret
  );

  modport slave (
    output opcode, memReady,
    input  pcWrite, pcWriteCond, pcSource, IorD, memRead, memWrite, irWrite,
           regWrite, memToReg, aluSrcA, aluSrcB, aluOp, illegalOp, state, instret
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I core. It steps each instruction through
// fetch, decode, execute, memory and writeback. It waits on memReady for memory
// accesses and counts retired instructions.
//
// Ports:
//   clk  - system clock; every state change happens on its rising edge
//   rst  - asynchronous, active-high reset
//   bus  - control bundle (master modport). Inputs: opcode, memReady.
//          Outputs: PC/IR/memory/regfile strobes, mux selects, aluOp, illegalOp,
//          debug state and instret.
//
// state     | meaning
// ----------+------------------------------------------------------------
// FETCH     | read instruction at PC, PC <= PC+4, IR/oldPC load on memReady
// DECODE    | dispatch on opcode; ALUOut <= oldPC + imm (branch/JAL target)
// MEM_ADDR  | ALUOut <= rs1 + imm (load/store address)
// MEM_READ  | data read at ALUOut, held until memReady
// MEM_WB    | rd <= MDR
// MEM_WRITE | data write at ALUOut, held until memReady
// EXEC_R    | ALU on rs1, rs2 using funct decode
// EXEC_I    | ALU on rs1, imm using funct decode
// ALU_WB    | rd <= ALUOut
// BRANCH    | compare rs1/rs2, PC <= ALUOut if taken
// JAL       | rd <= PC (already PC+4), PC <= ALUOut
// LUI       | rd <= imm
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_LUI       = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (bus.opcode)
      OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_LUI: op_legal = 1'b1;
      default:                                                  op_legal = 1'b0;
    endcase
  end

  // Next state and retire detection. An instruction retires on the edge that
  // takes it back to FETCH. An illegal opcode returns from DECODE without retiring.
  always_comb begin
    state_d = S_FETCH;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = bus.memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (bus.opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: state_d = bus.memReady ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: begin
        state_d = bus.memReady ? S_FETCH : S_MEM_WRITE;
        retire  = bus.memReady;
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL, S_LUI: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Moore output decode. Only the FETCH strobes and illegalOp look at inputs.
  always_comb begin
    bus.pcWrite     = 1'b0;
    bus.pcWriteCond = 1'b0;
    bus.pcSource    = 1'b0;
    bus.IorD        = 1'b0;
    bus.memRead     = 1'b0;
    bus.memWrite    = 1'b0;
    bus.irWrite     = 1'b0;
    bus.regWrite    = 1'b0;
    bus.memToReg    = 2'b00;
    bus.aluSrcA     = 2'b00;
    bus.aluSrcB     = 2'b00;
    bus.aluOp       = 2'b00;
    bus.illegalOp   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.memRead = 1'b1;
        bus.aluSrcB = 2'b01;
        bus.irWrite = bus.memReady;
        bus.pcWrite = bus.memReady;
      end
      S_DECODE: begin
        bus.aluSrcA   = 2'b01;
        bus.aluSrcB   = 2'b10;
        bus.illegalOp = ~op_legal;
      end
      S_MEM_ADDR: begin
        bus.aluSrcA = 2'b10;
        bus.aluSrcB = 2'b10;
      end
      S_MEM_READ: begin
        bus.memRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEM_WB: begin
        bus.regWrite = 1'b1;
        bus.memToReg = 2'b01;
      end
      S_MEM_WRITE: begin
        bus.memWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXEC_R: begin
        bus.aluSrcA = 2'b10;
        bus.aluOp   = 2'b10;
      end
      S_EXEC_I: begin
        bus.aluSrcA = 2'b10;
        bus.aluSrcB = 2'b10;
        bus.aluOp   = 2'b11;
      end
      S_ALU_WB: begin
        bus.regWrite = 1'b1;
      end
      S_BRANCH: begin
        bus.aluSrcA     = 2'b10;
        bus.aluOp       = 2'b01;
        bus.pcWriteCond = 1'b1;
        bus.pcSource    = 1'b1;
      end
      S_JAL: begin
        bus.regWrite = 1'b1;
        bus.memToReg = 2'b10;
        bus.pcWrite  = 1'b1;
        bus.pcSource = 1'b1;
      end
      S_LUI: begin
        bus.regWrite = 1'b1;
        bus.memToReg = 2'b11;
      end
      default: ;
    endcase
    // The state register resets to FETCH at once. FETCH would otherwise pass
    // memReady straight through to pcWrite/irWrite, so every write strobe is
    // held low for as long as reset is applied.
    if (rst) begin
      bus.pcWrite     = 1'b0;
      bus.pcWriteCond = 1'b0;
      bus.irWrite     = 1'b0;
      bus.regWrite    = 1'b0;
      bus.memRead     = 1'b0;
      bus.memWrite    = 1'b0;
    end
  end

  assign bus.state   = state_q;
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic clk = 1'b0;
  logic rst;
  logic rst4;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.CNT_W(32)) bus ();
  multicycle_control_fsm_if #(.CNT_W(4))  bus4 ();

  multicycle_control_fsm #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  multicycle_control_fsm #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst4), .bus(bus4));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {pcWrite,pcWriteCond,pcSource,IorD,memRead,memWrite,irWrite,regWrite,
  //  memToReg,aluSrcA,aluSrcB,aluOp,illegalOp}
  logic [16:0] act_ctrl;
  assign act_ctrl = {bus.pcWrite, bus.pcWriteCond, bus.pcSource, bus.IorD, bus.memRead,
                     bus.memWrite, bus.irWrite, bus.regWrite, bus.memToReg, bus.aluSrcA,
                     bus.aluSrcB, bus.aluOp, bus.illegalOp};

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_R) || (op == OP_I) ||
           (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_LUI);
  endfunction

  // Control word the active state should present, taken straight from the state descriptions.
  function automatic logic [16:0] exp_ctrl(input int st, input logic mr, input logic [6:0] op);
    logic pcw = 1'b0, pcwc = 1'b0, pcs = 1'b0, iord = 1'b0, mrd = 1'b0;
    logic mwr = 1'b0, irw = 1'b0, rw = 1'b0, ill = 1'b0;
    logic [1:0] m2r = 2'b00, a = 2'b00, b = 2'b00, aop = 2'b00;
    case (st)
      0:  begin mrd = 1'b1; b = 2'b01; irw = mr; pcw = mr; end
      1:  begin a = 2'b01; b = 2'b10; ill = !is_legal(op); end
      2:  begin a = 2'b10; b = 2'b10; end
      3:  begin mrd = 1'b1; iord = 1'b1; end
      4:  begin rw = 1'b1; m2r = 2'b01; end
      5:  begin mwr = 1'b1; iord = 1'b1; end
      6:  begin a = 2'b10; b = 2'b00; aop = 2'b10; end
      7:  begin a = 2'b10; b = 2'b10; aop = 2'b11; end
      8:  begin rw = 1'b1; m2r = 2'b00; end
      9:  begin a = 2'b10; aop = 2'b01; pcwc = 1'b1; pcs = 1'b1; end
      10: begin rw = 1'b1; m2r = 2'b10; pcw = 1'b1; pcs = 1'b1; end
      11: begin rw = 1'b1; m2r = 2'b11; end
      default: ;
    endcase
    return {pcw, pcwc, pcs, iord, mrd, mwr, irw, rw, m2r, a, b, aop, ill};
  endfunction

  // Reference model: each opcode maps to the list of states it visits after FETCH.
  // FETCH, MEM_READ and MEM_WRITE hold while memReady is low.
  int path[$];
  int m_idx;
  logic [31:0] m_instret;

  task automatic set_path(input logic [6:0] op);
    path.delete();
    path.push_back(1);
    case (op)
      OP_LOAD:   begin path.push_back(2); path.push_back(3); path.push_back(4); end
      OP_STORE:  begin path.push_back(2); path.push_back(5); end
      OP_R:      begin path.push_back(6); path.push_back(8); end
      OP_I:      begin path.push_back(7); path.push_back(8); end
      OP_BRANCH: path.push_back(9);
      OP_JAL:    path.push_back(10);
      OP_LUI:    path.push_back(11);
      default:   ;
    endcase
  endtask

  typedef struct {
    logic [6:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic        rw;
    logic        mw;
    logic        ill;
    logic [31:0] ir;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] op, input logic mr, input logic [3:0] st,
                              input logic rw, input logic mw, input logic ill,
                              input logic [31:0] ir);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.rw = rw; v.mw = mw; v.ill = ill; v.ir = ir;
    return v;
  endfunction

  vec_t vecs[21];
  logic [6:0] legal_ops[7];

  initial begin
    int cur;
    logic mr;
    logic [6:0] op;

    legal_ops[0] = OP_LOAD;  legal_ops[1] = OP_STORE; legal_ops[2] = OP_R;
    legal_ops[3] = OP_I;     legal_ops[4] = OP_BRANCH; legal_ops[5] = OP_JAL;
    legal_ops[6] = OP_LUI;

    // R-type, store, illegal, load with three wait cycles, then a FETCH wait.
    vecs[0]  = mk(OP_R,     1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 0);
    vecs[1]  = mk(OP_R,     1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 0);
    vecs[2]  = mk(OP_R,     1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 0);
    vecs[3]  = mk(OP_R,     1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 0);
    vecs[4]  = mk(OP_STORE, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1);
    vecs[5]  = mk(OP_STORE, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1);
    vecs[6]  = mk(OP_STORE, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1);
    vecs[7]  = mk(OP_STORE, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1);
    vecs[8]  = mk(OP_BAD,   1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 2);
    vecs[9]  = mk(OP_BAD,   1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 2);
    vecs[10] = mk(OP_LOAD,  1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 2);
    vecs[11] = mk(OP_LOAD,  1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2);
    vecs[12] = mk(OP_LOAD,  1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 2);
    vecs[13] = mk(OP_LOAD,  1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 2);
    vecs[14] = mk(OP_LOAD,  1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 2);
    vecs[15] = mk(OP_LOAD,  1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 2);
    vecs[16] = mk(OP_LOAD,  1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 2);
    vecs[17] = mk(OP_LOAD,  1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 2);
    vecs[18] = mk(OP_LOAD,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3);
    vecs[19] = mk(OP_R,     1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 3);
    vecs[20] = mk(OP_R,     1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 3);

    rst = 1'b1;
    rst4 = 1'b1;
    bus.opcode = OP_R;
    bus.memReady = 1'b1;
    bus4.opcode = OP_LUI;
    bus4.memReady = 1'b1;

    // Reset state: FETCH with memReady high, but every write strobe is held low.
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", bus.state, 0);
    chk("reset_instret", bus.instret, 0);
    chk("reset_pcWrite", bus.pcWrite, 0);
    chk("reset_irWrite", bus.irWrite, 0);
    chk("reset_memRead", bus.memRead, 0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 21; i++) begin
      bus.opcode = vecs[i].op;
      bus.memReady = vecs[i].mr;
      #1;
      chk($sformatf("vec%0d_state", i), bus.state, vecs[i].st);
      chk($sformatf("vec%0d_regWrite", i), bus.regWrite, vecs[i].rw);
      chk($sformatf("vec%0d_memWrite", i), bus.memWrite, vecs[i].mw);
      chk($sformatf("vec%0d_illegalOp", i), bus.illegalOp, vecs[i].ill);
      chk($sformatf("vec%0d_instret", i), bus.instret, vecs[i].ir);
      @(negedge clk);
    end

    // The R-type from the table is in EXEC_R here. It retires, then a store
    // stalls in MEM_WRITE and reset lands in the middle of it.
    bus.memReady = 1'b1;
    bus.opcode = OP_STORE;
    repeat (5) @(negedge clk);
    bus.memReady = 1'b0;
    #1;
    chk("stall_state", bus.state, 5);
    chk("stall_memWrite", bus.memWrite, 1);
    chk("stall_IorD", bus.IorD, 1);
    chk("stall_instret", bus.instret, 4);
    @(negedge clk);
    #1;
    chk("stall_hold_memWrite", bus.memWrite, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_memWrite", bus.memWrite, 0);
    chk("rstmid_state", bus.state, 0);
    chk("rstmid_instret", bus.instret, 0);
    bus.memReady = 1'b1;
    #1;
    chk("rstmid_pcWrite", bus.pcWrite, 0);
    chk("rstmid_irWrite", bus.irWrite, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.opcode = OP_R;
    #1;
    chk("rstrel_state", bus.state, 0);
    chk("rstrel_irWrite", bus.irWrite, 1);
    @(negedge clk);
    #1;
    chk("rstrel_first_edge", bus.state, 1);

    // Randomized run checked against the path model.
    @(negedge clk);
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    m_idx = -1;
    m_instret = 0;
    set_path(OP_R);
    for (int c = 0; c < 2000; c++) begin
      if (m_idx < 0) begin
        if ($urandom_range(0, 8) < 7) op = legal_ops[$urandom_range(0, 6)];
        else op = 7'($urandom);
        bus.opcode = op;
        set_path(op);
      end
      mr = ($urandom_range(0, 3) != 0);
      bus.memReady = mr;
      #1;
      cur = (m_idx < 0) ? 0 : path[m_idx];
      chk("rand_state", bus.state, cur);
      chk("rand_ctrl", act_ctrl, exp_ctrl(cur, mr, bus.opcode));
      chk("rand_instret", bus.instret, m_instret);
      if (!((cur == 0 || cur == 3 || cur == 5) && !mr)) begin
        m_idx++;
        if (m_idx == path.size()) begin
          if (path.size() > 1) m_instret++;
          m_idx = -1;
        end
      end
      @(negedge clk);
    end

    // 4-bit counter: 16 back-to-back LUIs (3 cycles each) wrap instret to 0.
    rst4 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      repeat (3) @(negedge clk);
      #1;
      chk($sformatf("wrap_instret_%0d", k), bus4.instret, k % 16);
    end
    chk("wrap_state", bus4.state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
